// File: rtl/pipeline_hazard_if.sv
// rtl/pipeline_hazard_if.sv - decode/execute hazard inputs and IF/ID sequencing outputs
interface pipeline_hazard_if #(
    parameter int PERF_W = 32
) ();
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_branch;
    logic              id_mdu;
    logic              id_mfhilo;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [4:0]        ex_write_addr;
    logic              mem_mem_read;
    logic [4:0]        mem_write_addr;
    logic              branch_taken;
    logic              jump;
    logic              pc_write;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              mdu_start;
    logic              mdu_busy;
    logic [PERF_W-1:0] perf_stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_mdu, id_mfhilo,
               ex_reg_write, ex_mem_read, ex_write_addr, mem_mem_read, mem_write_addr,
               branch_taken, jump,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_start, mdu_busy,
               perf_stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_mdu, id_mfhilo,
               ex_reg_write, ex_mem_read, ex_write_addr, mem_mem_read, mem_write_addr,
               branch_taken, jump,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_start, mdu_busy,
               perf_stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - IF/ID advance/stall/flush control for load-use, branch and MDU hazards
module pipeline_hazard_ctrl #(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 6,
    parameter int PERF_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_hazard_if.slave hz
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] perf_q;
    logic              ex_match, mem_match;
    logic              h_lu, h_br1, h_br2;
    logic              data_stall, mdu_stall, stall;

    // $0 is hardwired zero, so a write to it can never feed a consumer
    always_comb begin
        ex_match   = (hz.ex_write_addr != 5'd0) &&
                     ((hz.id_use_rs && (hz.ex_write_addr == hz.id_rs)) ||
                      (hz.id_use_rt && (hz.ex_write_addr == hz.id_rt)));
        mem_match  = (hz.mem_write_addr != 5'd0) &&
                     ((hz.id_use_rs && (hz.mem_write_addr == hz.id_rs)) ||
                      (hz.id_use_rt && (hz.mem_write_addr == hz.id_rt)));
        h_lu       = hz.ex_mem_read && ex_match;
        h_br1      = hz.id_branch && hz.ex_reg_write && ex_match;
        h_br2      = hz.id_branch && hz.mem_mem_read && mem_match;
        data_stall = h_lu || h_br1 || h_br2;
        mdu_stall  = (state_q == BUSY) && (hz.id_mdu || hz.id_mfhilo);
        stall      = data_stall || mdu_stall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hz.id_mdu && !data_stall) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(MDU_CYCLES - 1);
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset forces a squash of both pipeline registers and freezes the PC
    always_comb begin
        hz.pc_write    = !rst && !stall;
        hz.if_id_write = !rst && !stall;
        hz.if_id_flush = rst || (!stall && (hz.branch_taken || hz.jump));
        hz.id_ex_flush = rst || stall;
        hz.mdu_start   = !rst && (state_q == IDLE) && hz.id_mdu && !data_stall;
        hz.mdu_busy    = !rst && (state_q == BUSY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (stall && (perf_q != {PERF_W{1'b1}})) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    assign hz.perf_stall_cnt = perf_q;
endmodule
